preprocess_dp1_loader: RTL and testbench

- Upstream feeder for the preprocess INTT stage. Accepts a coefficient stream (valid/ready) and writes it into the DP1 polyvec port.
- Pulses INTT start, waits for INTT done, then streams the transformed coefficients back out through the DP1 read port with full backpressure.
- Sits between the VPU coefficient source and preprocess_top's io_i_dp1_*/io_i_intt_start/io_o_intt_done pins.

---
 rtl/preprocess_pkg.sv | 30 +++
 rtl/preprocess_rd_fifo.sv | 47 ++++
 rtl/preprocess_dp1_loader.sv | 152 +++++++++++++++
 tb/tb_preprocess_dp1_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/preprocess_pkg.sv
// Shared types and helpers for the preprocess DP1 loader: FSM states, default
// geometry and the address bit-reversal used for bit-reversed DP1 loads.
package preprocess_pkg;

    localparam int unsigned PV_DW        = 35;
    localparam int unsigned NUM_COEFF    = 4096;
    localparam int unsigned BITREV_MAX_W = 16;
    localparam int unsigned BR_IW        = $clog2(BITREV_MAX_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    // Reverse the low w bits of x; bits at or above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                       input int unsigned w);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < w) r[BR_IW'(i)] = x[BR_IW'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/preprocess_rd_fifo.sv
// Small synchronous FIFO catching DP1 read data; count feeds the read-credit check.
module preprocess_rd_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/preprocess_dp1_loader.sv
// Loads a coefficient stream into DP1, kicks the INTT, then streams the
// transformed coefficients back out with credit-based read issue.
module preprocess_dp1_loader #(
    parameter int unsigned DATA_WIDTH = 39,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned PV_DW      = preprocess_pkg::PV_DW,
    parameter int unsigned NUM_COEFF  = preprocess_pkg::NUM_COEFF,
    parameter int unsigned BITREV     = 0,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_wide,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  o_dp1_wren,
    output logic [ADDR_WIDTH-1:0] o_dp1_wraddr,
    output logic [DATA_WIDTH-1:0] o_dp1_wrdata,
    output logic [ADDR_WIDTH-1:0] o_dp1_rdaddr,
    input  logic [DATA_WIDTH-1:0] i_dp1_rddata,
    output logic                  o_intt_start,
    input  logic                  i_intt_done
);
    import preprocess_pkg::*;

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = RD_LATENCY + 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_COEFF - 1);
    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_COEFF);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       load_cnt;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       out_cnt;
    logic [RD_LATENCY-1:0]  rd_vld;
    logic                   err_wide;
    logic                   s_beat;
    logic                   issue;
    logic                   pop;
    logic                   fifo_empty;
    logic [FCNT_W-1:0]      fifo_cnt;
    logic [PV_DW-1:0]       fifo_head;
    logic [3:0]             inflight;
    logic [ADDR_WIDTH-1:0]  load_addr;
    logic                   rddata_unused;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        o_intt_start = 1'b0;
        o_done       = 1'b0;
        case (state)
            ST_IDLE:   if (i_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid && load_cnt == LAST) state_nxt = ST_KICK;
            end
            ST_KICK: begin
                o_intt_start = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT:   if (i_intt_done) state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (pop && out_cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_cnt  <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            err_wide  <= 1'b0;
        end else begin
            if (state == ST_IDLE && i_start) begin
                load_cnt  <= '0;
                issue_cnt <= '0;
                out_cnt   <= '0;
                err_wide  <= 1'b0;
            end
            if (s_beat) begin
                load_cnt <= load_cnt + CNT_W'(1);
                if (|s_data[DATA_WIDTH-1:PV_DW]) err_wide <= 1'b1;
            end
            if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
            if (pop)   out_cnt   <= out_cnt + CNT_W'(1);
        end
    end

    // Valid bits track each issued read until its data appears on i_dp1_rddata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_vld <= '0;
        else       rd_vld <= RD_LATENCY'({rd_vld, issue});
    end

    // Credit: reads in flight plus buffered words never exceed FIFO depth;
    // a same-cycle pop frees one slot so full rate is kept with m_ready high.
    assign inflight = 4'($countones(rd_vld));
    assign issue    = (state == ST_UNLOAD) && (issue_cnt < TOTAL) &&
                      ((inflight + 4'(fifo_cnt)) < (4'(DEPTH) + 4'(pop)));

    preprocess_rd_fifo #(
        .WIDTH (PV_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_vld[RD_LATENCY-1]),
        .push_data (i_dp1_rddata[PV_DW-1:0]),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign rddata_unused = ^i_dp1_rddata[DATA_WIDTH-1:PV_DW];

    assign load_addr = (BITREV != 0)
                     ? ADDR_WIDTH'(bitrev(BITREV_MAX_W'(load_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH))
                     : load_cnt[ADDR_WIDTH-1:0];

    assign s_beat       = s_valid && s_ready;
    assign o_dp1_wren   = s_beat;
    assign o_dp1_wraddr = s_beat ? load_addr : '0;
    assign o_dp1_wrdata = s_beat ? DATA_WIDTH'(s_data[PV_DW-1:0]) : '0;
    assign o_dp1_rdaddr = issue_cnt[ADDR_WIDTH-1:0];

    assign m_valid    = (state == ST_UNLOAD) && !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? DATA_WIDTH'(fifo_head) : '0;
    assign o_busy     = (state != ST_IDLE);
    assign o_err_wide = err_wide;

endmodule

// File: tb/tb_preprocess_dp1_loader.sv
// Directed bench: natural and bit-reversed loader instances against a DP1/INTT model.
module tb_preprocess_dp1_loader;

    localparam int unsigned DW = 39;
    localparam int unsigned AW = 12;
    localparam int          N  = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          sel;
    logic          start_v, s_valid_v, m_ready_v, done_force;
    logic [DW-1:0] s_data_v;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    logic          a_busy, a_done, a_err, a_s_ready, a_m_valid, a_wren, a_intt_start, a_intt_done;
    logic          b_busy, b_done, b_err, b_s_ready, b_m_valid, b_wren, b_intt_start, b_intt_done;
    logic [DW-1:0] a_m_data, a_wrdata, a_rddata, b_m_data, b_wrdata, b_rddata;
    logic [AW-1:0] a_wraddr, a_rdaddr, b_wraddr, b_rdaddr;

    preprocess_dp1_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PV_DW(35), .NUM_COEFF(N), .BITREV(0), .RD_LATENCY(1)
    ) u_dut_a (
        .clock(clock), .reset(reset), .i_start(start_v & ~sel), .o_busy(a_busy),
        .o_done(a_done), .o_err_wide(a_err), .s_valid(s_valid_v & ~sel), .s_ready(a_s_ready),
        .s_data(s_data_v), .m_valid(a_m_valid), .m_ready(m_ready_v), .m_data(a_m_data),
        .o_dp1_wren(a_wren), .o_dp1_wraddr(a_wraddr), .o_dp1_wrdata(a_wrdata),
        .o_dp1_rdaddr(a_rdaddr), .i_dp1_rddata(a_rddata), .o_intt_start(a_intt_start),
        .i_intt_done(a_intt_done)
    );

    preprocess_dp1_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PV_DW(35), .NUM_COEFF(N), .BITREV(1), .RD_LATENCY(3)
    ) u_dut_b (
        .clock(clock), .reset(reset), .i_start(start_v & sel), .o_busy(b_busy),
        .o_done(b_done), .o_err_wide(b_err), .s_valid(s_valid_v & sel), .s_ready(b_s_ready),
        .s_data(s_data_v), .m_valid(b_m_valid), .m_ready(m_ready_v), .m_data(b_m_data),
        .o_dp1_wren(b_wren), .o_dp1_wraddr(b_wraddr), .o_dp1_wrdata(b_wrdata),
        .o_dp1_rdaddr(b_rdaddr), .i_dp1_rddata(b_rddata), .o_intt_start(b_intt_start),
        .i_intt_done(b_intt_done)
    );

    // View of whichever instance is under test.
    logic          v_busy, v_done, v_err, v_s_ready, v_m_valid, v_wren, v_intt_start;
    logic [DW-1:0] v_m_data, v_wrdata;
    logic [AW-1:0] v_wraddr, v_rdaddr;
    assign v_busy       = sel ? b_busy       : a_busy;
    assign v_done       = sel ? b_done       : a_done;
    assign v_err        = sel ? b_err        : a_err;
    assign v_s_ready    = sel ? b_s_ready    : a_s_ready;
    assign v_m_valid    = sel ? b_m_valid    : a_m_valid;
    assign v_wren       = sel ? b_wren       : a_wren;
    assign v_intt_start = sel ? b_intt_start : a_intt_start;
    assign v_m_data     = sel ? b_m_data     : a_m_data;
    assign v_wrdata     = sel ? b_wrdata     : a_wrdata;
    assign v_wraddr     = sel ? b_wraddr     : a_wraddr;
    assign v_rdaddr     = sel ? b_rdaddr     : a_rdaddr;

    // DP1 bank plus INTT model: reads return stored word + 7, done 50 cycles after start.
    for (genvar g = 0; g < 2; g++) begin : mdl
        logic [DW-1:0] mem [N];
        logic [DW-1:0] p0, p1, p2;
        int            dcnt;
        logic          wren, ks;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        assign wren = (g == 1) ? b_wren       : a_wren;
        assign ks   = (g == 1) ? b_intt_start : a_intt_start;
        assign wa   = (g == 1) ? b_wraddr     : a_wraddr;
        assign ra   = (g == 1) ? b_rdaddr     : a_rdaddr;
        assign wd   = (g == 1) ? b_wrdata     : a_wrdata;
        always @(posedge clock) begin
            if (wren) mem[wa] <= wd;
            p0 <= mem[ra] + DW'(7);
            p1 <= p0;
            p2 <= p1;
        end
        always @(posedge clock or posedge reset) begin
            if (reset)                        dcnt <= 0;
            else if (ks)                      dcnt <= 1;
            else if (dcnt != 0 && dcnt < 50)  dcnt <= dcnt + 1;
        end
    end
    assign a_rddata    = mdl[0].p0;
    assign b_rddata    = mdl[1].p2;
    assign a_intt_done = (mdl[0].dcnt == 50) || (done_force && !sel);
    assign b_intt_done = (mdl[1].dcnt == 50) || (done_force && sel);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rev12(input logic [AW-1:0] x);
        return {<<{x}};
    endfunction

    function automatic logic [DW-1:0] exp_out(input bit brv, input int k, input int wide_beat);
        int src;
        src = brv ? int'(rev12(AW'(k))) : k;
        return (src == wide_beat) ? DW'(8) : DW'(src + 7);
    endfunction

    task automatic run_pass(input bit g, input bit force_d, input int wide_beat,
                            input int abort_after, input bit bp);
        int k, t_kick, t_first, t_last, bound;
        bit seen;
        sel = g;
        done_force = force_d;
        start_v = 1'b1;
        s_valid_v = 1'b0;
        m_ready_v = 1'b0;
        tick();
        start_v = 1'b0;
        #1;
        chk("busy_load", v_busy, 1);
        chk("s_ready_load", v_s_ready, 1);
        chk("err_cleared", v_err, 0);
        for (int i = 0; i < N; i++) begin
            if (bp && (i % 5 == 2)) begin
                s_valid_v = 1'b0;
                #1;
                chk("no_write_gap", v_wren, 0);
                tick();
            end
            s_valid_v = 1'b1;
            s_data_v  = (i == wide_beat) ? 39'h40_0000_0001 : DW'(i);
            start_v   = (i == 20);
            #1;
            chk("wren", v_wren, 1);
            chk("wraddr", v_wraddr, g ? rev12(AW'(i)) : AW'(i));
            chk("wrdata", v_wrdata, (i == wide_beat) ? 1 : i);
            if (wide_beat >= 0 && i == wide_beat + 1) chk("err_set", v_err, 1);
            tick();
        end
        start_v = 1'b0;
        #1;
        chk("kick_start", v_intt_start, 1);
        chk("kick_no_ready", v_s_ready, 0);
        chk("kick_no_write", v_wren, 0);
        t_kick = cyc;
        s_valid_v = 1'b0;
        tick();
        chk("start_one_pulse", v_intt_start, 0);
        k = 0; seen = 0; bound = 0; t_first = 0; t_last = 0;
        while (k < N && bound < 20000) begin
            m_ready_v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (v_m_valid && !seen) begin
                seen = 1;
                t_first = cyc;
            end
            if (v_m_valid && m_ready_v) begin
                chk("m_data", v_m_data, exp_out(g, k, wide_beat));
                k++;
                t_last = cyc;
            end
            if (abort_after >= 0 && k == abort_after) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", v_busy, 0);
                chk("rst_m_valid", v_m_valid, 0);
                chk("rst_m_data", v_m_data, 0);
                chk("rst_s_ready", v_s_ready, 0);
                chk("rst_wren", v_wren, 0);
                chk("rst_rdaddr", v_rdaddr, 0);
                chk("rst_intt_start", v_intt_start, 0);
                chk("rst_done", v_done, 0);
                m_ready_v = 1'b0;
                repeat (2) @(posedge clock);
                #2;
                reset = 1'b0;
                return;
            end
            tick();
            bound++;
        end
        m_ready_v = 1'b0;
        chk("all_out", k, N);
        if (!bp) chk("throughput", t_last - t_first, N - 1);
        if (force_d) chk("kick_to_valid_forced", t_first - t_kick, 4);
        else if (!bp) chk("kick_to_valid", t_first - t_kick, 53);
        chk("done_pulse", v_done, 1);
        chk("busy_done", v_busy, 1);
        chk("no_valid_after", v_m_valid, 0);
        tick();
        chk("done_one_cycle", v_done, 0);
        chk("idle_busy", v_busy, 0);
        chk("err_wide_final", v_err, wide_beat >= 0);
        done_force = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0;
        start_v = 1'b0;
        s_valid_v = 1'b0;
        m_ready_v = 1'b0;
        done_force = 1'b0;
        s_data_v = '0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("reset_busy", v_busy, 0);
            chk("reset_s_ready", v_s_ready, 0);
            chk("reset_m_valid", v_m_valid, 0);
            chk("reset_wren", v_wren, 0);
            chk("reset_intt_start", v_intt_start, 0);
            chk("reset_done", v_done, 0);
            chk("reset_err", v_err, 0);
        end
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        tick();

        run_pass(1'b0, 1'b0, -1, -1, 1'b0);
        run_pass(1'b0, 1'b1, 10, -1, 1'b0);
        run_pass(1'b0, 1'b0, -1, 100, 1'b0);
        run_pass(1'b0, 1'b0, -1, -1, 1'b0);

        sel = 1'b1;
        s_valid_v = 1'b1;
        s_data_v = DW'(5);
        #1;
        chk("idle_no_ready", v_s_ready, 0);
        chk("idle_no_write", v_wren, 0);
        tick();
        run_pass(1'b1, 1'b0, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
